gate_truth_table_checker: RTL and testbench
===========================================

Name: gate_truth_table_checker

Overview:
- Self-checking stimulus/capture stage that sits directly around a two-input basic-gate block.
- Drives the gate block's inputs a,b through all four combinations and waits a programmable settle time per vector.
- Samples the seven gate outputs c..i each vector and compares them against the expected truth table.
- Reports the result through a start/busy/done handshake with a pass flag and an error count.

Parameters:
- SETTLE_CYCLES, 1: cycles {a,b} is held before sampling; legal range 1..255; value 0 is treated as 1.
- ORDER, 0: output mapping expected on c..i.
  - 0: c=~a, d=a&b, e=a|b, f=~(a&b), g=~(a|b), h=a^b, i=~(a^b).
  - 1: c=~a, d=a&b, e=a|b, f=a^b, g=~(a&b), h=~(a|b), i=~(a^b).

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  run request; sampled only in IDLE
- a  out  1  gate input A (registered)
- b  out  1  gate input B (registered)
- c,d,e,f,g,h,i  in  1 each  gate outputs under test; mismatch-mask bit order c=bit0 .. i=bit6
- busy  out  1  high in DRIVE and SAMPLE
- done  out  1  one-cycle pulse in DONE state
- pass  out  1  high when the last run had err_count==0; held until next accepted start
- err_count  out  3  number of failing vectors in the current/last run (0..4)

Behaviour:
- Reset: rst_n low at a rising edge puts every output at 0 on that edge (a, b, busy, done, pass, err_count) and the FSM in IDLE. Reset overrides all other activity, including mid-run; an aborted run produces no done.
- States and transitions:
  - IDLE: start=1 -> DRIVE. On the same edge: vec=0, {a,b}=vec, settle counter=0, err_count=0, pass=0.
  - DRIVE: {a,b} held. Counter increments each cycle. After SETTLE_CYCLES cycles in DRIVE -> SAMPLE.
  - SAMPLE: exactly one cycle; {a,b} still held. c..i are compared to the expected values for vec under ORDER. Any mismatched bit makes the vector failing; err_count increments by 1 on the exiting edge. If vec==3 -> DONE, else vec+1, {a,b} updated, counter cleared -> DRIVE.
  - DONE: done=1, busy=0. pass=1 iff final err_count==0. Unconditional -> IDLE.
- Vector order: {a,b} = 00, 01, 10, 11 (a is the MSB of vec).
- Latency: an accepted start at edge 0 gives the DONE cycle at cycle 4*(SETTLE_CYCLES+1)+1.
- start is ignored outside IDLE, including in the DONE cycle; no queueing. Level-high start relaunches a run on the cycle after DONE.
- a, b, err_count and pass hold their values in IDLE after a run.
- err_count saturates by construction at 4. The vec counter is 2 bits and never wraps within a run.
- Comparisons use the values present on c..i during the SAMPLE cycle only; glitches in DRIVE are ignored.

Optional Feature:
- Macro GATE_CHK_ERR_LOG_EN.
- When defined, adds outputs:
  - first_fail_valid (1)
  - first_fail_vec (2): {a,b} of the first failing vector
  - first_fail_mask (7): XOR of actual vs expected c..i for that vector
- These are captured only on the first failing SAMPLE of a run. They are cleared to 0 on reset and on an accepted start, and held after DONE.
- When undefined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Golden ORDER=0 gate model, SETTLE_CYCLES=1, start pulse at edge 0 -> {a,b}=00,01,10,11 each for 2 cycles; done pulse in cycle 9; pass=1; err_count=0.
- ORDER=0 checker on an ORDER=1-mapped gate model -> vectors 00,01,10 fail, 11 passes; err_count=3; pass=0. With GATE_CHK_ERR_LOG_EN: first_fail_vec=00, first_fail_mask=7'h28 (f and h), first_fail_valid=1.
- Golden model with d stuck at 0 -> only vector 11 fails; err_count=1; pass=0. With log: first_fail_vec=11, first_fail_mask=7'h02.
- SETTLE_CYCLES=3, golden model -> each vector held 4 cycles; done in cycle 17 after start; start pulses in cycles 3 and 17 have no effect.
- rst_n low during the SAMPLE of vec=10 -> next cycle a=b=0, busy=0, err_count=0, pass=0, no done pulse. A following start runs a full clean sequence to pass=1.
- Back-to-back: start held high through a run -> new run begins the cycle after DONE; err_count clears at relaunch; the previous pass is overwritten only at the next DONE.

Source files
------------

// File: rtl/gate_truth_table_checker.sv
// Drives a two-input gate block through all four {a,b} vectors and checks its seven outputs.
// Optional first-failure log: define GATE_CHK_ERR_LOG_EN.
module gate_truth_table_checker #(
   parameter int SETTLE_CYCLES = 1,
   parameter int ORDER         = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       a,
   output logic       b,
   input  logic       c,
   input  logic       d,
   input  logic       e,
   input  logic       f,
   input  logic       g,
   input  logic       h,
   input  logic       i,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count
`ifdef GATE_CHK_ERR_LOG_EN
   ,
   output logic       first_fail_valid,
   output logic [1:0] first_fail_vec,
   output logic [6:0] first_fail_mask
`endif
);

   // A settle time of 0 would skip DRIVE entirely, so it is promoted to 1.
   localparam int         SETTLE      = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

   state_t     state, state_nxt;
   logic [1:0] vec;
   logic [7:0] cnt;
   logic [6:0] actual, expected, mismatch;
   logic       vec_fail;
   logic       g_not, g_and, g_or, g_xor;

   assign a      = vec[1];
   assign b      = vec[0];
   assign actual = {i, h, g, f, e, d, c};

   always_comb begin
      g_not = ~vec[1];
      g_and = &vec;
      g_or  = |vec;
      g_xor = ^vec;
      if (ORDER == 1)
         expected = {~g_xor, ~g_or, ~g_and, g_xor, g_or, g_and, g_not};
      else
         expected = {~g_xor, g_xor, ~g_or, ~g_and, g_or, g_and, g_not};
   end

   assign mismatch = actual ^ expected;
   assign vec_fail = |mismatch;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = DRIVE;
         DRIVE:   if (cnt == SETTLE_LAST) state_nxt = SAMPLE;
         SAMPLE:  state_nxt = (vec == 2'd3) ? DONE : DRIVE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == DRIVE) || (state == SAMPLE);
      done = (state == DONE);
   end

   // Datapath: vector, settle counter, score; all hold outside their owning state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vec       <= '0;
         cnt       <= '0;
         err_count <= '0;
         pass      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               vec       <= '0;
               cnt       <= '0;
               err_count <= '0;
               pass      <= 1'b0;
            end
            DRIVE: cnt <= cnt + 8'd1;
            SAMPLE: begin
               if (vec_fail) err_count <= err_count + 3'd1;
               if (vec == 2'd3) begin
                  pass <= (err_count == 3'd0) && !vec_fail;
               end else begin
                  vec <= vec + 2'd1;
                  cnt <= '0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef GATE_CHK_ERR_LOG_EN
   always_ff @(posedge clk) begin
      if (!rst_n || (state == IDLE && start)) begin
         first_fail_valid <= 1'b0;
         first_fail_vec   <= '0;
         first_fail_mask  <= '0;
      end else if (state == SAMPLE && vec_fail && !first_fail_valid) begin
         first_fail_valid <= 1'b1;
         first_fail_vec   <= vec;
         first_fail_mask  <= mismatch;
      end
   end
`endif

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Bench: two checkers (SETTLE 1/ORDER 0, SETTLE 3/ORDER 1) around table-driven gate models with
// per-vector fault masks; expectations come from counting the injected faults.
module tb_gate_truth_table_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst_n;
   logic [1:0]          start, a_o, b_o, busy_o, done_o, pass_o;
   logic [1:0][2:0]     err_o;
   logic [1:0][6:0]     gv;
`ifdef GATE_CHK_ERR_LOG_EN
   logic [1:0]          ffv_o;
   logic [1:0][1:0]     ffvec_o;
   logic [1:0][6:0]     ffm_o;
`endif
   logic [6:0]          corr [2][4];

   // Truth tables, bit0=c .. bit6=i, indexed by {a,b}; row 0 is ORDER 0, row 1 is ORDER 1.
   localparam logic [6:0] TAB [2][4] = '{'{7'h59, 7'h2D, 7'h2C, 7'h46},
                                         '{7'h71, 7'h1D, 7'h1C, 7'h46}};
   localparam int SET [2] = '{1, 3};

   always_comb begin
      gv[0] = TAB[0][{a_o[0], b_o[0]}] ^ corr[0][{a_o[0], b_o[0]}];
      gv[1] = TAB[1][{a_o[1], b_o[1]}] ^ corr[1][{a_o[1], b_o[1]}];
   end

   gate_truth_table_checker #(.SETTLE_CYCLES(1), .ORDER(0)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .a(a_o[0]), .b(b_o[0]),
      .c(gv[0][0]), .d(gv[0][1]), .e(gv[0][2]), .f(gv[0][3]), .g(gv[0][4]), .h(gv[0][5]), .i(gv[0][6]),
      .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .err_count(err_o[0])
`ifdef GATE_CHK_ERR_LOG_EN
      , .first_fail_valid(ffv_o[0]), .first_fail_vec(ffvec_o[0]), .first_fail_mask(ffm_o[0])
`endif
   );

   gate_truth_table_checker #(.SETTLE_CYCLES(3), .ORDER(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .a(a_o[1]), .b(b_o[1]),
      .c(gv[1][0]), .d(gv[1][1]), .e(gv[1][2]), .f(gv[1][3]), .g(gv[1][4]), .h(gv[1][5]), .i(gv[1][6]),
      .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .err_count(err_o[1])
`ifdef GATE_CHK_ERR_LOG_EN
      , .first_fail_valid(ffv_o[1]), .first_fail_vec(ffvec_o[1]), .first_fail_mask(ffm_o[1])
`endif
   );

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   function automatic logic [3:0] ctl(input int id);
      return {a_o[id], b_o[id], busy_o[id], done_o[id]};
   endfunction

   task automatic chk_log(input string nm, input int id, input int err, input logic [1:0] fv,
                          input logic [6:0] fm);
`ifdef GATE_CHK_ERR_LOG_EN
      chk({nm, " log"}, {ffv_o[id], ffvec_o[id], ffm_o[id]},
          (err != 0) ? {1'b1, fv, fm} : 10'h0);
`else
      if (nm.len() == 0) $display("%0d %0h %0h %0d", err, fv, fm, id);
`endif
   endtask

   // Reference: a vector fails iff its injected fault mask is non-zero.
   task automatic model(input int id, output int err, output logic [1:0] fv, output logic [6:0] fm);
      err = 0; fv = '0; fm = '0;
      for (int v = 0; v < 4; v++)
         if (corr[id][v] != 7'h00) begin
            if (err == 0) begin fv = 2'(v); fm = corr[id][v]; end
            err++;
         end
   endtask

   task automatic do_run(input int id, input string nm, input int err, input logic [1:0] fv,
                         input logic [6:0] fm, input bit noise);
      int per = SET[id] + 1;
      int n   = 4 * per;
      @(negedge clk) start[id] = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < n; k++) begin
         start[id] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         chk({nm, " seq"}, ctl(id), {2'(k / per), 2'b10});
         @(posedge clk); #1;
      end
      chk({nm, " done"}, ctl(id), 4'b1101);
      chk({nm, " err"}, err_o[id], 3'(err));
      chk({nm, " pass"}, pass_o[id], (err == 0));
      chk_log(nm, id, err, fv, fm);
      start[id] = noise ? 1'b1 : 1'b0;   // start during DONE must be ignored
      @(posedge clk); #1;
      start[id] = 1'b0;
      chk({nm, " idle"}, {ctl(id), err_o[id], pass_o[id]}, {4'b1100, 3'(err), (err == 0)});
      @(posedge clk); #1;
      chk({nm, " no relaunch"}, ctl(id), 4'b1100);
      chk_log({nm, " held"}, id, err, fv, fm);
   endtask

   typedef struct {
      int         id;
      logic [6:0] corr [4];
      int         err;
      logic [1:0] fv;
      logic [6:0] fm;
      bit         noise;
   } dir_t;

   dir_t tbl [5];

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{0, '{7'h00, 7'h00, 7'h00, 7'h00}, 0, 2'd0, 7'h00, 1'b0};  // golden
      tbl[1] = '{0, '{7'h28, 7'h30, 7'h30, 7'h00}, 3, 2'd0, 7'h28, 1'b0};  // ORDER 1 gate
      tbl[2] = '{0, '{7'h00, 7'h00, 7'h00, 7'h02}, 1, 2'd3, 7'h02, 1'b0};  // d stuck 0
      tbl[3] = '{1, '{7'h00, 7'h00, 7'h00, 7'h00}, 0, 2'd0, 7'h00, 1'b1};  // settle 3, start noise
      tbl[4] = '{1, '{7'h00, 7'h00, 7'h00, 7'h02}, 1, 2'd3, 7'h02, 1'b1};

      rst_n = 1'b0; start = '0;
      for (int id = 0; id < 2; id++) for (int v = 0; v < 4; v++) corr[id][v] = '0;
      repeat (2) @(posedge clk); #1;
      for (int id = 0; id < 2; id++) begin
         chk("reset", {ctl(id), err_o[id], pass_o[id]}, 8'h00);
         chk_log("reset", id, 0, 2'd0, 7'h00);
      end
      rst_n = 1'b1;

      for (int t = 0; t < 5; t++) begin
         corr[tbl[t].id] = tbl[t].corr;
         do_run(tbl[t].id, $sformatf("dir%0d", t), tbl[t].err, tbl[t].fv, tbl[t].fm, tbl[t].noise);
      end

      // Reset during SAMPLE of vector 10, after vector 00 already failed.
      corr[0] = '{7'h01, 7'h00, 7'h00, 7'h00};
      @(negedge clk) start[0] = 1'b1;
      @(posedge clk); #1 start[0] = 1'b0;
      repeat (5) @(posedge clk); #1;
      chk("rst pre", {ctl(0), err_o[0]}, {4'b1010, 3'd1});
      rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      chk("rst mid", {ctl(0), err_o[0], pass_o[0]}, 8'h00);
      chk_log("rst mid", 0, 0, 2'd0, 7'h00);
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         chk("rst quiet", {busy_o[0], done_o[0]}, 2'b00);
      end
      corr[0] = '{7'h00, 7'h00, 7'h00, 7'h00};
      do_run(0, "post rst", 0, 2'd0, 7'h00, 1'b0);

      // Back-to-back on the SETTLE=3 checker: failing run, then a clean relaunch.
      corr[1] = '{7'h00, 7'h00, 7'h10, 7'h00};
      @(negedge clk) start[1] = 1'b1;
      @(posedge clk); #1;
      repeat (16) @(posedge clk); #1;
      chk("b2b done1", {ctl(1), err_o[1], pass_o[1]}, {4'b1101, 3'd1, 1'b0});
      corr[1] = '{7'h00, 7'h00, 7'h00, 7'h00};
      @(posedge clk); #1;
      chk("b2b idle", {ctl(1), err_o[1], pass_o[1]}, {4'b1100, 3'd1, 1'b0});
      @(posedge clk); #1;
      chk("b2b relaunch", {ctl(1), err_o[1]}, {4'b0010, 3'd0});
      start[1] = 1'b0;
      repeat (16) @(posedge clk); #1;
      chk("b2b done2", {ctl(1), err_o[1], pass_o[1]}, {4'b1101, 3'd0, 1'b1});
      @(posedge clk); #1;
      chk("b2b end", ctl(1), 4'b1100);

      // Random fault patterns against the counting model.
      for (int r = 0; r < 16; r++) begin
         int         id, err;
         logic [1:0] fv;
         logic [6:0] fm;
         id = int'($urandom_range(0, 1));
         for (int v = 0; v < 4; v++)
            corr[id][v] = ($urandom_range(0, 1) == 1) ? 7'h00 : 7'($urandom_range(1, 127));
         model(id, err, fv, fm);
         do_run(id, $sformatf("rnd%0d", r), err, fv, fm, 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
